// File: rtl/bw_mult_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Baugh-Wooley multiplier.
package bw_mult_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int ROW_IDX_W = 6;

  // Rows summed per pipeline stage; the last stage takes whatever is left.
  function automatic int rows_per_stage(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Signed-mode correction: ones at bit WIDTH and at bit 2*WIDTH-1.
  function automatic logic [2*MAX_WIDTH-1:0] bw_correction(input int width);
    logic [2*MAX_WIDTH-1:0] c;
    c = '0;
    c[width] = 1'b1;
    c[2*width-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One shifted partial-product row, with Baugh-Wooley inversion of the sign cross terms.
module bw_pp_row
  import bw_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]     x,
  input  logic                 y_bit,
  input  logic [ROW_IDX_W-1:0] row,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   pp_row
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] bits_s;

  // A term is inverted when exactly one of its row/column indices is the sign position
  always_comb begin
    bits_s = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (signed_mode && ((row == LAST_ROW) != (j == WIDTH - 1))) begin
        bits_s[j] = ~(x[j] & y_bit);
      end else begin
        bits_s[j] = x[j] & y_bit;
      end
    end
  end

  assign pp_row = {{WIDTH{1'b0}}, bits_s} << row;

endmodule

// File: rtl/bw_mult_pipe.sv
// Pipelined Baugh-Wooley multiplier, per-transaction signed/unsigned, valid/ready on both sides.
module bw_mult_pipe
  import bw_mult_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z
);

  localparam int                     RPS       = rows_per_stage(WIDTH, STAGES);
  localparam logic [2*MAX_WIDTH-1:0] CORR_FULL = bw_correction(WIDTH);
  localparam logic [2*WIDTH-1:0]     CORR      = CORR_FULL[2*WIDTH-1:0];

  logic                 advance_s;
  logic [STAGES:0]      valid_r;
  logic [STAGES-1:0]    mode_r;
  logic [WIDTH-1:0]     x_r   [STAGES];
  logic [WIDTH-1:0]     y_r   [STAGES];
  logic [2*WIDTH-1:0]   sum_r [STAGES+1];
  logic [2*WIDTH-1:0]   acc_s [STAGES];
  logic [2*WIDTH-1:0]   rows_s[WIDTH];

  // One global stall: the whole pipe moves only when the output slot can drain.
  assign advance_s = ~valid_r[STAGES] | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_r[STAGES];
  assign z         = sum_r[STAGES];

  // Row i is fed from the operand copy held in front of the stage that sums it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    localparam int SI = i / RPS;
    bw_pp_row #(.WIDTH(WIDTH)) u_row (
      .x           (x_r[SI]),
      .y_bit       (y_r[SI][i]),
      .row         (ROW_IDX_W'(i)),
      .signed_mode (mode_r[SI]),
      .pp_row      (rows_s[i])
    );
  end

  // Each stage adds its own group of rows onto the running sum it received
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      acc_s[s] = sum_r[s];
      for (int i = 0; i < WIDTH; i++) begin
        if ((i / RPS) == s) begin
          acc_s[s] = acc_s[s] + rows_s[i];
        end else begin
          acc_s[s] = acc_s[s];
        end
      end
    end
  end

  // Pipeline registers; data only moves with a valid token, everything holds on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      mode_r  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        x_r[k] <= '0;
        y_r[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        sum_r[k] <= '0;
      end
    end else if (advance_s) begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        x_r[0]    <= x;
        y_r[0]    <= y;
        mode_r[0] <= signed_mode;
        // The correction constant rides in as the initial running sum.
        sum_r[0]  <= signed_mode ? CORR : '0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
        if (valid_r[k-1]) begin
          sum_r[k] <= acc_s[k-1];
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (valid_r[k-1]) begin
          x_r[k]    <= x_r[k-1];
          y_r[k]    <= y_r[k-1];
          mode_r[k] <= mode_r[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_bw_mult_pipe.sv
// Self-checking bench: directed table on WIDTH=4/STAGES=2, random sweeps on WIDTH=8.
module tb_bw_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit start_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] gold8(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint sa, sb, p;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    p = sa * sb;
    return p[15:0];
  endfunction

  // ---------------- WIDTH=4, STAGES=2 directed instance ----------------
  logic       a_iv, a_ir, a_sm, a_ov, a_or;
  logic [3:0] a_x, a_y;
  logic [7:0] a_z;

  bw_mult_pipe #(.WIDTH(4), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .y(a_y),
    .signed_mode(a_sm), .out_valid(a_ov), .out_ready(a_or), .z(a_z)
  );

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       sm;
    logic [7:0] z;
  } vec_t;

  vec_t tbl[13];

  task automatic drive_vec(input int idx);
    a_iv = 1'b1;
    a_x  = tbl[idx].x;
    a_y  = tbl[idx].y;
    a_sm = tbl[idx].sm;
  endtask

  // Holds each operand until accepted, stalls the consumer for a window, checks order/holding.
  task automatic run_stream(input int first, input int cnt, input int stall_from, input int stall_len);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [7:0] prev_z = 8'h00;
    bit prev_stalled = 1'b0;
    while (got < cnt && cyc < 60) begin
      @(negedge clk);
      a_or = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (sent < cnt) drive_vec(first + sent);
      else a_iv = 1'b0;
      #1;
      if (prev_stalled) begin
        chk("stall_z_hold", 64'(a_z), 64'(prev_z));
        chk("stall_ov_hold", 64'(a_ov), 64'd1);
      end
      if (a_ov && !a_or) chk("stall_in_ready", 64'(a_ir), 64'd0);
      if (a_ov && a_or) begin
        chk($sformatf("stream_z[%0d]", first + got), 64'(a_z), 64'(tbl[first + got].z));
        got++;
      end
      if (a_iv && a_ir) sent++;
      prev_stalled = a_ov && !a_or;
      prev_z = a_z;
      cyc++;
    end
    chk("stream_count", 64'(got), 64'(cnt));
    a_iv = 1'b0;
    a_or = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1 chk("stream_no_dup", 64'(a_ov), 64'd0);
    end
  endtask

  // ---------------- WIDTH=8 random instances, STAGES in {1,3,8} ----------------
  localparam int NR = 2000;

  for (genvar c = 0; c < 3; c++) begin : g_rand
    localparam int S = (c == 0) ? 1 : ((c == 1) ? 3 : 8);
    logic        iv, ir, sm, ov, ordy;
    logic [7:0]  xx, yy;
    logic [15:0] zz;
    logic [15:0] exp_q[$];
    bit          done = 1'b0;

    bw_mult_pipe #(.WIDTH(8), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .x(xx), .y(yy),
      .signed_mode(sm), .out_valid(ov), .out_ready(ordy), .z(zz)
    );

    initial begin
      int n_acc, n_got, guard;
      logic [15:0] e;
      iv = 1'b0; xx = 8'h00; yy = 8'h00; sm = 1'b0; ordy = 1'b1;
      wait (start_rand);
      n_acc = 0; n_got = 0; guard = 0;
      while ((n_acc < NR || n_got < NR) && guard < NR * 8) begin
        @(negedge clk);
        iv   = (n_acc < NR) && ($urandom_range(0, 4) != 0);
        xx   = 8'($urandom);
        yy   = 8'($urandom);
        sm   = 1'($urandom_range(0, 1));
        ordy = ($urandom_range(0, 3) != 0);
        #1;
        if (ov && ordy) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("rand_s%0d_spurious", S), 64'(zz), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("rand_s%0d_z", S), 64'(zz), 64'(e));
          end
          n_got++;
        end
        if (iv && ir) begin
          exp_q.push_back(gold8(xx, yy, sm));
          n_acc++;
        end
        guard++;
      end
      iv = 1'b0;
      chk($sformatf("rand_s%0d_count", S), 64'(n_got), 64'(NR));
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    tbl[0]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
    tbl[1]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 8'h01};
    tbl[3]  = '{4'h8, 4'h8, 1'b0, 8'h40};
    tbl[4]  = '{4'h7, 4'h7, 1'b1, 8'h31};
    tbl[5]  = '{4'hF, 4'h8, 1'b1, 8'h08};
    tbl[6]  = '{4'h0, 4'hF, 1'b0, 8'h00};
    tbl[7]  = '{4'hF, 4'h1, 1'b0, 8'h0F};
    tbl[8]  = '{4'h8, 4'h1, 1'b1, 8'hF8};
    tbl[9]  = '{4'h5, 4'h3, 1'b1, 8'h0F};
    tbl[10] = '{4'h5, 4'hE, 1'b1, 8'hF6};
    tbl[11] = '{4'hC, 4'hC, 1'b0, 8'h90};
    tbl[12] = '{4'h8, 4'h8, 1'b1, 8'h40};

    a_iv = 1'b0; a_x = 4'h0; a_y = 4'h0; a_sm = 1'b0; a_or = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ov", 64'(a_ov), 64'd0);
    chk("reset_z", 64'(a_z), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("reset_in_ready", 64'(a_ir), 64'd1);

    // single accept: most-negative squared, latency
    @(negedge clk);
    a_or = 1'b1;
    drive_vec(12);
    #1 chk("t1_in_ready", 64'(a_ir), 64'd1);
    @(negedge clk);
    a_iv = 1'b0;
    #1 chk("t1_ov_edge1", 64'(a_ov), 64'd0);
    @(negedge clk);
    #1 chk("t1_ov_edge2", 64'(a_ov), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_ov_edge3", 64'(a_ov), 64'd1);
    chk("t1_z", 64'(a_z), 64'h40);
    @(negedge clk);
    #1 chk("t1_ov_after", 64'(a_ov), 64'd0);

    // back-to-back: products on consecutive cycles, in order
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc < 3) drive_vec(cyc);
      else a_iv = 1'b0;
      #1;
      if (cyc < 3) begin
        chk("b2b_in_ready", 64'(a_ir), 64'd1);
        chk("b2b_ov_early", 64'(a_ov), 64'd0);
      end else if (cyc < 6) begin
        chk($sformatf("b2b_ov[%0d]", cyc - 3), 64'(a_ov), 64'd1);
        chk($sformatf("b2b_z[%0d]", cyc - 3), 64'(a_z), 64'(tbl[cyc - 3].z));
      end else begin
        chk("b2b_ov_end", 64'(a_ov), 64'd0);
      end
    end

    // backpressure windows
    run_stream(3, 4, 2, 5);
    run_stream(7, 6, 4, 3);
    run_stream(0, 13, 1, 2);

    // asynchronous reset with three products in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_vec(k);
    end
    @(negedge clk);
    a_iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov", 64'(a_ov), 64'd0);
    chk("rst_z", 64'(a_z), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1 chk("rst_no_stale", 64'(a_ov), 64'd0);
    end
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    run_stream(10, 1, 0, 0);

    // randomized sweeps
    start_rand = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
    end
    chk("rand_complete", 64'({g_rand[0].done, g_rand[1].done, g_rand[2].done}), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
